pipe_scroller: RTL
==================

// Module: pipe_scroller
// PURPOSE
//  Upstream sequencer for the pipe drawer: owns the positions of all on-screen pipes.
//  On each game tick it walks the pipes one at a time. Per pipe: erase at the old position,
//  move left by SPEED (wrapping to SPAWN_X with a new gap height), then redraw.
//  Drives the drawer's enable/pipe_x/pipe_y/erase and consumes its done pulse.
//  Publishes all pipe positions for collision logic.
// PARAMETERS
//  NUM_PIPES  3    pipes managed (1..4)
//  SPEED      4    pixels moved left per tick
//  SPAWN_X    700  x assigned on wrap and to pipe 0 at reset
//  SPACING    240  reset x spacing: pipe i x = SPAWN_X + i*SPACING (must stay < 2048)
//  Y_MIN      240  lowest gap y; gap y = Y_MIN + 7-bit offset (range Y_MIN..Y_MIN+127)
// PORTS
//  clk          in   1            system clock
//  reset        in   1            asynchronous, active-low reset
//  tick         in   1            1-cycle game-frame pulse
//  run          in   1            0 = freeze; ticks ignored, no tick_missed
//  draw_done    in   1            drawer done pulse (1 cycle)
//  draw_en      out  1            drawer enable (level)
//  draw_erase   out  1            1 = current draw is an erase (background colour)
//  pipe_x       out  11           x of pipe being drawn/erased
//  pipe_y       out  11           y of pipe being drawn/erased
//  pipes_x      out  11*NUM_PIPES  all pipe x, pipe i at [11*i +: 11]
//  pipes_y      out  11*NUM_PIPES  all pipe y, same packing
//  busy         out  1            1 while any state other than IDLE
//  tick_missed  out  1            sticky; set when tick && run arrives while busy
// BEHAVIOUR
//  Reset (async, reset==0):
//   - FSM = IDLE, idx = 0, draw_en = draw_erase = busy = tick_missed = 0.
//   - pipe i: x = SPAWN_X + i*SPACING, y = Y_MIN + 64*i; LFSR = 8'hA5.
//  Reset mid-operation: draw_en drops immediately. The drawer is reset by the same net.
//  FSM (registered state; draw_en, draw_erase and busy are decoded from state only):
//   - IDLE:  tick && run -> ERASE, idx = 0. Otherwise stay.
//   - ERASE: draw_en = 1, draw_erase = 1; pipe_x/pipe_y = old position of pipe idx.
//            draw_done -> MOVE.
//   - MOVE:  1 cycle, draw_en = 0. Update pipe idx:
//            - if x <= SPEED: x = SPAWN_X, step LFSR once, y = Y_MIN + stepped_lfsr[6:0]
//            - else: x = x - SPEED, y unchanged
//            -> DRAW.
//   - DRAW:  draw_en = 1, draw_erase = 0; pipe_x/pipe_y = new position. draw_done -> NEXT.
//   - NEXT:  1 cycle, draw_en = 0. idx == NUM_PIPES-1 -> IDLE; else idx++, -> ERASE.
//  Drawer handshake:
//   - draw_en is low for >= 1 cycle after every done, so the drawer never auto-restarts.
//   - pipe_x/pipe_y are held stable for the whole time draw_en is high.
//   - draw_done outside ERASE/DRAW is ignored.
//  Latency: busy rises 1 cycle after the accepted tick. A per-pipe pass is 2 drawer runs + 2 cycles.
//  tick arriving during busy: dropped (no queue), tick_missed set until reset.
//  run falling mid-pass: the current pass completes; only new ticks are gated.
//  LFSR: 8-bit Galois, right shift, mask 8'hB8. It steps only on a wrap. A5 -> EA -> 75.
//  Arithmetic: unsigned 11-bit. The x <= SPEED test precedes the subtraction, so no underflow.
// CONFIGURATION
//  PIPE_RANDOM_EN defined: gap y on wrap comes from the LFSR as above.
//  PIPE_RANDOM_EN undefined:
//   - No LFSR logic.
//   - Wrap y = Y_MIN + table[k], table = {0, 96, 32, 64}.
//   - k is a 2-bit counter, reset 0, incremented after each wrap (shared across pipes).
// STRUCTURE
//  pipe_pkg:
//   - COORD_W = 11, SCREEN_W = 640, SCREEN_H = 480
//   - scroll_state_t enum {IDLE, ERASE, MOVE, DRAW, NEXT}
//   - GAP_TABLE constant
//  Sub-module pipe_lfsr (clk, reset, step, value[7:0]); instantiated only under PIPE_RANDOM_EN.
// TESTING
//  - Reset release, no tick, 10 cycles -> busy = 0, draw_en = 0, pipes_x = {1180, 940, 700},
//    pipes_y = {368, 304, 240}.
//  - tick, drawer model returns done 5 cycles after enable ->
//    - erase (700, 240, erase = 1), then draw (696, 240, erase = 0)
//    - then pipes 1 and 2 the same way
//    - busy falls after the 3rd draw; draw_en is low >= 1 cycle between runs.
//  - Preload pipe 0 x = 4 (run ticks), tick, PIPE_RANDOM_EN defined -> pipe 0 x = 700, y = 346
//    (lfsr EA); the next wrap gives y = 357 (lfsr 75).
//  - Same wrap without PIPE_RANDOM_EN -> y = 240, then 336 on the next wrap.
//  - tick while busy -> no extra pass, tick_missed = 1 and stays 1. run = 0 tick -> nothing, tick_missed unchanged.
//  - reset asserted during DRAW -> draw_en and busy drop the same cycle, positions return to reset values.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared coordinate width, scroller states, gap table and LFSR step for the pipe scroller.
package pipe_pkg;
  localparam int COORD_W = 11;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, NEXT} scroll_state_t;
  localparam logic [3:0][6:0] GAP_TABLE = {7'd64, 7'd32, 7'd96, 7'd0};
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction
endpackage

// File: rtl/pipe_lfsr.sv
// pipe_lfsr: 8-bit Galois LFSR (mask B8, seed A5) that advances only when step is high.
module pipe_lfsr
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] value
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) value <= 8'hA5;
    else if (step) value <= lfsr_next(value);
endmodule

// File: rtl/pipe_scroller.sv
// pipe_scroller: per-tick erase/move/redraw sequencer for all on-screen pipes.
// Define PIPE_RANDOM_EN for LFSR gap heights; otherwise gaps cycle through GAP_TABLE.
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int NUM_PIPES = 3,
  parameter int SPEED     = 4,
  parameter int SPAWN_X   = 700,
  parameter int SPACING   = 240,
  parameter int Y_MIN     = 240
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           run,
  input  logic                           draw_done,
  output logic                           draw_en,
  output logic                           draw_erase,
  output logic [COORD_W-1:0]             pipe_x,
  output logic [COORD_W-1:0]             pipe_y,
  output logic [COORD_W*NUM_PIPES-1:0]   pipes_x,
  output logic [COORD_W*NUM_PIPES-1:0]   pipes_y,
  output logic                           busy,
  output logic                           tick_missed
);
  localparam logic [1:0] LAST = 2'(NUM_PIPES - 1);
  localparam logic [COORD_W-1:0] SPD = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] SPAWN = COORD_W'(SPAWN_X);
  scroll_state_t state, nxt;
  logic [1:0] idx;
  logic [COORD_W-1:0] xs [NUM_PIPES];
  logic [COORD_W-1:0] ys [NUM_PIPES];
  logic [6:0] gap;
  logic wrap;
  assign wrap = xs[idx] <= SPD;
`ifdef PIPE_RANDOM_EN
  logic [7:0] lfsr_val, lfsr_nx;
  pipe_lfsr u_lfsr (.clk(clk), .reset(reset), .step(state == MOVE && wrap), .value(lfsr_val));
  assign lfsr_nx = lfsr_next(lfsr_val);
  assign gap = lfsr_nx[6:0];
`else
  logic [1:0] k;
  always_ff @(posedge clk or negedge reset)
    if (!reset) k <= 2'd0;
    else if (state == MOVE && wrap) k <= k + 2'd1;
  assign gap = GAP_TABLE[k];
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (tick && run) ? ERASE : IDLE;
      ERASE:   nxt = draw_done ? MOVE : ERASE;
      MOVE:    nxt = DRAW;
      DRAW:    nxt = draw_done ? NEXT : DRAW;
      NEXT:    nxt = (idx == LAST) ? IDLE : ERASE;
      default: nxt = IDLE;
    endcase
  end
  assign draw_en = state == ERASE || state == DRAW;
  assign draw_erase = state == ERASE;
  assign busy = state != IDLE;
  assign pipe_x = xs[idx];
  assign pipe_y = ys[idx];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx <= 2'd0;
      tick_missed <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        xs[i] <= COORD_W'(SPAWN_X + i * SPACING);
        ys[i] <= COORD_W'(Y_MIN + 64 * i);
      end
    end else begin
      if (tick && run && busy) tick_missed <= 1'b1;
      if (state == IDLE && tick && run) idx <= 2'd0;
      if (state == NEXT && idx != LAST) idx <= idx + 2'd1;
      if (state == MOVE) begin
        xs[idx] <= wrap ? SPAWN : xs[idx] - SPD;
        if (wrap) ys[idx] <= COORD_W'(Y_MIN) + {4'd0, gap};
      end
    end
  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign pipes_x[COORD_W*g +: COORD_W] = xs[g];
    assign pipes_y[COORD_W*g +: COORD_W] = ys[g];
  end
endmodule
